// File: rtl/fetch_inst_queue_pkg.sv
// fetch_inst_queue_pkg: shared widths, default sizing and the queue entry type for the fetch buffer.
package fetch_inst_queue_pkg;
    localparam int ADDR_W          = 32;
    localparam int INST_W          = 32;
    localparam int FETCH_WIDTH_DEF = 2;
    localparam int DEPTH_DEF       = 8;
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } FetchEntry_t;
endpackage

// File: rtl/fetch_lane_compact.sv
// fetch_lane_compact: per-lane write offset (prefix count of enabled lanes) and total enabled count.
module fetch_lane_compact #(
    parameter int FETCH_WIDTH = 2,
    parameter int OW          = $clog2(FETCH_WIDTH + 1)
) (
    input  logic [FETCH_WIDTH-1:0]    i_en_n,
    output logic [FETCH_WIDTH*OW-1:0] o_offset,
    output logic [OW-1:0]             o_total
);
    logic [OW-1:0] w_acc;
    always_comb begin
        w_acc    = '0;
        o_offset = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            o_offset[i*OW +: OW] = w_acc;
            w_acc                = w_acc + OW'(!i_en_n[i]);
        end
        o_total = w_acc;
    end
endmodule

// File: rtl/fetch_inst_queue.sv
// fetch_inst_queue: multi-lane fetch-to-decode buffer; compacts enabled lanes, delivers one
// instruction per cycle in program order, stalls fetch on low space, flushes on redirect.
module fetch_inst_queue
    import fetch_inst_queue_pkg::*;
#(
    parameter int ADDR        = ADDR_W,
    parameter int INST        = INST_W,
    parameter int FETCH_WIDTH = FETCH_WIDTH_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int CNT         = $clog2(DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        reset_,
    input  logic                        flush_,
    input  logic [FETCH_WIDTH-1:0]      fetch_e_,
    input  logic [FETCH_WIDTH*ADDR-1:0] fetch_pc,
    input  logic [FETCH_WIDTH*INST-1:0] fetch_inst,
    output logic                        fetch_stall,
    output logic                        inst_e_,
    output logic [ADDR-1:0]             inst_pc,
    output logic [INST-1:0]             inst,
    input  logic                        dec_stall,
    output logic [CNT-1:0]              count
);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(FETCH_WIDTH + 1);

    logic [PW-1:0]             r_head, r_tail;
    logic [CNT-1:0]            r_count;
    logic [ADDR-1:0]           r_pc   [DEPTH];
    logic [INST-1:0]           r_inst [DEPTH];
    logic [FETCH_WIDTH*OW-1:0] w_offset;
    logic [OW-1:0]             w_k;
    logic                      w_push, w_pop;

    fetch_lane_compact #(.FETCH_WIDTH(FETCH_WIDTH), .OW(OW)) u_compact (
        .i_en_n   (fetch_e_),
        .o_offset (w_offset),
        .o_total  (w_k)
    );

    // Stall looks only at registered occupancy, so a same-cycle pop never frees space early.
    assign fetch_stall = (CNT'(DEPTH) - r_count) < CNT'(FETCH_WIDTH);
    assign count       = r_count;
    assign inst_e_     = r_count == '0;
    assign inst_pc     = inst_e_ ? '0 : r_pc[r_head];
    assign inst        = inst_e_ ? '0 : r_inst[r_head];
    assign w_push      = flush_ && !fetch_stall;
    assign w_pop       = !inst_e_ && !dec_stall;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (!flush_) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PW'(w_pop);
            r_tail  <= r_tail + (w_push ? PW'(w_k) : '0);
            r_count <= r_count + (w_push ? CNT'(w_k) : '0) - CNT'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (!fetch_e_[i]) begin
                    r_pc[r_tail + PW'(w_offset[i*OW +: OW])]   <= fetch_pc[i*ADDR +: ADDR];
                    r_inst[r_tail + PW'(w_offset[i*OW +: OW])] <= fetch_inst[i*INST +: INST];
                end
            end
        end
    end
endmodule
